// File: rtl/input_pkg.sv
// Shared types and constants for the rotary encoder / push-switch front end.
package input_pkg;

  // Push-switch handling states.
  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } btn_state_t;

  // Encoder rest position between detents (both contacts open).
  localparam logic [1:0] QUAD_DETENT = 2'b11;

  // Single-bit transitions that make up one full detent.
  localparam int QUAD_STEPS = 4;

  // Next {A,B} state in the clockwise sequence 11 -> 01 -> 00 -> 10 -> 11.
  function automatic logic [1:0] quad_cw_next(input logic [1:0] ab);
    case (ab)
      2'b11:   return 2'b01;
      2'b01:   return 2'b00;
      2'b00:   return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer followed by a stability counter: the output follows
// the synchronized input only after it has disagreed for CYCLES clocks.
module debounce #(
  parameter int   CYCLES = 27000,
  parameter logic INIT   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous pin into the clk domain.
  // NOTE: registers use non-blocking assignments so sync1 -> sync2 is a true
  // two-stage pipeline; blocking here would collapse it into one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= INIT;
      sync2 <= INIT;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Accept a new level only once it has been stable long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= INIT;
      cnt  <= '0;
    end else if (sync2 == dout) begin
      cnt <= '0;
    end else if (cnt == CW'(CYCLES - 1)) begin
      dout <= sync2;
      cnt  <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rotary_input_decoder.sv
// Rotary encoder + push switch front end: debounced quadrature decoding into
// detent step pulses and a wrapped cursor, plus short/long press pulses.
module rotary_input_decoder #(
  parameter int DEBOUNCE_CYCLES   = 27000,
  parameter int LONG_PRESS_CYCLES = 13500000,
  parameter int POS_MAX           = 7
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rotary_a,
  input  logic                             rotary_b,
  input  logic                             rotary_sw,
  output logic [$clog2(POS_MAX+1)-1:0]     pos,
  output logic                             step_cw,
  output logic                             step_ccw,
  output logic                             sw_level,
  output logic                             sw_short,
  output logic                             sw_long
);

  import input_pkg::*;

  localparam int PW          = $clog2(POS_MAX + 1);
  localparam int HW          = $clog2(LONG_PRESS_CYCLES + 1);
  // Long enough for a switch held through reset to appear on the debounced
  // output before presses are accepted.
  localparam int BOOT_CYCLES = DEBOUNCE_CYCLES + 4;
  localparam int BW          = $clog2(BOOT_CYCLES + 1);

  localparam logic signed [3:0] SUB_FULL  = 4'(QUAD_STEPS);
  localparam logic [HW-1:0]     HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic              db_a;
  logic              db_b;
  logic              db_sw;
  logic [1:0]        ab;
  logic [1:0]        prev_ab;
  logic signed [3:0] sub;
  logic signed [3:0] sub_next;
  logic              at_detent;
  logic              cw_hit;
  logic              ccw_hit;
  logic              pressed;
  btn_state_t        state;
  logic [HW-1:0]     hold;
  logic [BW-1:0]     boot_cnt;
  logic              booted;

  debounce #(.CYCLES(DEBOUNCE_CYCLES), .INIT(1'b1)) u_db_a (
    .clk(clk), .rst_n(rst_n), .din(rotary_a), .dout(db_a)
  );
  debounce #(.CYCLES(DEBOUNCE_CYCLES), .INIT(1'b1)) u_db_b (
    .clk(clk), .rst_n(rst_n), .din(rotary_b), .dout(db_b)
  );
  debounce #(.CYCLES(DEBOUNCE_CYCLES), .INIT(1'b1)) u_db_sw (
    .clk(clk), .rst_n(rst_n), .din(rotary_sw), .dout(db_sw)
  );

  assign ab       = {db_a, db_b};
  assign pressed  = ~db_sw;
  assign sw_level = pressed;

  // Sub-step count after the current {A,B} change and detent completion flags.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    sub_next = '0;
    if (ab == quad_cw_next(prev_ab)) begin
      sub_next = sub + 4'sd1;
    end else if (prev_ab == quad_cw_next(ab)) begin
      sub_next = sub - 4'sd1;
    end
    at_detent = (ab != prev_ab) && (ab == QUAD_DETENT);
    cw_hit    = at_detent && (sub_next == SUB_FULL);
    ccw_hit   = at_detent && (sub_next == -SUB_FULL);
  end

  // Track quadrature progress and emit one pulse per completed detent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ab  <= QUAD_DETENT;
      sub      <= '0;
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
    end else begin
      step_cw  <= cw_hit;
      step_ccw <= ccw_hit;
      if (ab != prev_ab) begin
        prev_ab <= ab;
        sub     <= at_detent ? 4'sd0 : sub_next;
      end
    end
  end

  // Cursor moves with the step pulses, wrapping within 0..POS_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
    end else if (cw_hit) begin
      pos <= (pos == PW'(POS_MAX)) ? '0 : pos + PW'(1);
    end else if (ccw_hit) begin
      pos <= (pos == '0) ? PW'(POS_MAX) : pos - PW'(1);
    end
  end

  // Startup window after reset during which a press counts as already held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_cnt <= '0;
      booted   <= 1'b0;
    end else if (!booted) begin
      if (boot_cnt == BW'(BOOT_CYCLES - 1)) begin
        booted <= 1'b1;
      end else begin
        boot_cnt <= boot_cnt + BW'(1);
      end
    end
  end

  // Button FSM: short press on early release, long press once at the hold limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold     <= '0;
      sw_short <= 1'b0;
      sw_long  <= 1'b0;
    end else begin
      sw_short <= 1'b0;
      sw_long  <= 1'b0;
      case (state)
        IDLE: begin
          if (pressed) begin
            hold  <= '0;
            // A switch held across reset must be released before it can act.
            state <= booted ? PRESSED : LONG_HELD;
          end
        end
        PRESSED: begin
          if (!pressed) begin
            sw_short <= 1'b1;
            state    <= IDLE;
          end else if (hold == HOLD_LAST) begin
            sw_long <= 1'b1;
            state   <= LONG_HELD;
          end else begin
            hold <= hold + HW'(1);
          end
        end
        LONG_HELD: begin
          if (!pressed) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
